// File: rtl/sum_reader.sv
// sum_reader: streams a finished result vector out of the sum memory over a valid/ready port.
// Optional running checksum output enabled by defining SUM_READER_CHECKSUM_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; len sampled here
// FETCH   | read strobe issued for element idx
// CAPTURE | memory data registered into out_data
// SEND    | element presented; holds until out_ready
// DONE    | one-cycle completion pulse, idx cleared
module sum_reader #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  len,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef SUM_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  len_q;
    logic [DATA_W-1:0] data_q;
    logic              is_last;

    // idx never reaches len_q in SEND, so the decrement cannot underflow in use
    assign is_last  = (idx == (len_q - IDX_W'(1)));
    assign rd_idx   = rd_en ? idx : '0;
    assign out_data = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                rd_en     = 1'b1;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_last  = is_last;
                if (out_ready) begin
                    state_nxt = is_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx    <= '0;
            len_q  <= '0;
            data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q <= len;
                        idx   <= '0;
                    end
                end
                S_CAPTURE: begin
                    data_q <= rd_data;
                end
                S_SEND: begin
                    if (out_ready && !is_last) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SUM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    assign checksum = checksum_q;

    // wraps modulo 2^DATA_W; holds after DONE until the next honoured start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else if (state == S_IDLE && start) begin
            checksum_q <= '0;
        end else if (out_valid && out_ready) begin
            checksum_q <= checksum_q + out_data;
        end
    end
`endif

endmodule

// File: tb/tb_sum_reader.sv
// Scoreboard bench for sum_reader: stimulus queues expected beats/reads, a negedge monitor checks them.
// Checksum checks are compiled in when SUM_READER_CHECKSUM_EN is defined.
module tb_sum_reader;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [IDX_W-1:0]  len = '0;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef SUM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    sum_reader #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef SUM_READER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    int                rdq[$];
    logic [DATA_W-1:0] mem[256];
    int                checks = 0;
    int                errors = 0;
    int                stall_cycles = 0;
    int                stall_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // memory model: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_idx];
    end

    // consumer: withholds ready for stall_cycles cycles on each beat
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && stall_cnt < stall_cycles) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
                if (!out_valid) stall_cnt = 0;
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rd_en) begin
                    if (rdq.size() == 0) begin
                        chk("unexpected_rd_en", 1, 0);
                    end else begin
                        chk("rd_idx", rd_idx, rdq.pop_front());
                    end
                end else begin
                    chk("rd_idx_idle_zero", rd_idx, 0);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        chk("out_data", out_data, exp_q[0].data);
                        chk("out_last", out_last, exp_q[0].last);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic run(input int n, input int stall, input int extra_at, input int exp_cycles);
        int cnt;
        int busy_cnt;
        int done_at;
        int first_v;
        int bad;
        logic [DATA_W-1:0] sum;
        sum = '0;
        stall_cycles = stall;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({mem[i], (i == n - 1) ? 1'b1 : 1'b0});
            rdq.push_back(i);
            sum = sum + mem[i];
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        len = IDX_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        len = IDX_W'($urandom);
        cnt = 0;
        busy_cnt = 0;
        done_at = -1;
        first_v = -1;
        while (cnt < exp_cycles + 20) begin
            @(negedge clk);
            cnt++;
            if (cnt == extra_at) begin
                start = 1'b1;
                len = 8'd9;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (out_valid && first_v < 0) first_v = cnt;
            if (done) begin
                done_at = cnt;
`ifdef SUM_READER_CHECKSUM_EN
                chk("checksum_at_done", checksum, sum);
`endif
                break;
            end
        end
        chk("done_cycle", done_at, exp_cycles);
        chk("busy_cycles", busy_cnt, exp_cycles);
        chk("first_valid_cycle", first_v, (n > 0) ? 3 : -1);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy || done) bad = 1;
        end
        chk("idle_after_done", bad, 0);
        chk("beats_left", exp_q.size(), 0);
        chk("reads_left", rdq.size(), 0);
        stall_cycles = 0;
    endtask

    initial begin
        int bad;
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // basic stream
        mem[0] = 32'd10; mem[1] = 32'd20; mem[2] = 32'd30;
        run(3, 0, -1, 10);

        // backpressure, 5 stall cycles per beat
        mem[0] = 32'hAAAA_0001; mem[1] = 32'hAAAA_0002;
        run(2, 5, -1, 17);

        // zero length
        run(0, 0, -1, 1);

        // start with len=9 during SEND of a len=4 transfer
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        run(4, 0, 3, 13);

        // start coinciding with DONE is ignored
        run(4, 0, 13, 13);

        // reset during SEND of element 1 of 5
        for (int i = 0; i < 5; i++) begin
            mem[i] = 32'h100 + i;
            exp_q.push_back({mem[i], (i == 4) ? 1'b1 : 1'b0});
            rdq.push_back(i);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        len = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_send_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rd_en", rd_en, 0);
        chk("async_rd_idx", rd_idx, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_out_last", out_last, 0);
        chk("async_out_data", out_data, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
`ifdef SUM_READER_CHECKSUM_EN
        chk("async_checksum", checksum, 0);
`endif
        exp_q.delete();
        rdq.delete();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy || out_valid || rd_en) bad = 1;
        end
        chk("idle_after_reset", bad, 0);
        mem[0] = 32'h5; mem[1] = 32'h6;
        run(2, 0, -1, 7);

`ifdef SUM_READER_CHECKSUM_EN
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0002;
        run(2, 0, -1, 7);
        chk("checksum_wrap_hold", checksum, 32'h0000_0001);
        run(0, 0, -1, 1);
        chk("checksum_zero_len", checksum, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
